// File: rtl/upsample_layer_sequencer_if.sv
// Command, completion and start signals between the layer sequencer (master)
// and the DMA read/write engines plus the upsample core (slave).
interface upsample_layer_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mm2s_cmd_valid;
    logic                  mm2s_cmd_ready;
    logic [ADDR_WIDTH-1:0] mm2s_addr;
    logic [16:0]           mm2s_len;
    logic                  s2mm_cmd_valid;
    logic                  s2mm_cmd_ready;
    logic [ADDR_WIDTH-1:0] s2mm_addr;
    logic [16:0]           s2mm_len;
    logic                  mm2s_done;
    logic                  s2mm_done;
    logic                  up_done;
    logic                  up_start;
    logic [2:0]            up_size;

    modport master (
        output mm2s_cmd_valid, mm2s_addr, mm2s_len,
        output s2mm_cmd_valid, s2mm_addr, s2mm_len,
        output up_start, up_size,
        input  mm2s_cmd_ready, s2mm_cmd_ready,
        input  mm2s_done, s2mm_done, up_done
    );

    modport slave (
        input  mm2s_cmd_valid, mm2s_addr, mm2s_len,
        input  s2mm_cmd_valid, s2mm_addr, s2mm_len,
        input  up_start, up_size,
        output mm2s_cmd_ready, s2mm_cmd_ready,
        output mm2s_done, s2mm_done, up_done
    );
endinterface

// File: rtl/upsample_layer_sequencer.sv
// Walks every channel of a layer range, issuing a DMA read/write command pair and an
// upsample-core start per channel, then waits for all three completions before advancing.
module upsample_layer_sequencer #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] SRC_BASE       = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] DST_BASE       = 32'h2000_0000,
    parameter int                    TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [2:0]                 first_layer,
    input  logic [2:0]                 last_layer,
    upsample_layer_sequencer_if.master bus,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [2:0]                 cur_layer,
    output logic [8:0]                 cur_channel
);

    localparam int          PAD_W       = ADDR_WIDTH - 17;
    localparam logic [31:0] WAIT_LAST_C = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        ADVANCE = 3'd4,
        FINISH  = 3'd5,
        ERROR   = 3'd6
    } state_t;

    // Fixed layer table: the last layer has half the channels, pixel count grows 4x per layer.
    function automatic logic [7:0] last_channel_f(input logic [2:0] layer);
        case (layer)
            3'd4:    last_channel_f = 8'd127;
            default: last_channel_f = 8'd255;
        endcase
    endfunction

    function automatic logic [16:0] in_bytes_f(input logic [2:0] layer);
        case (layer)
            3'd0:    in_bytes_f = 17'd64;
            3'd1:    in_bytes_f = 17'd256;
            3'd2:    in_bytes_f = 17'd1024;
            3'd3:    in_bytes_f = 17'd4096;
            3'd4:    in_bytes_f = 17'd16384;
            default: in_bytes_f = 17'd0;
        endcase
    endfunction

    function automatic logic [16:0] out_bytes_f(input logic [2:0] layer);
        case (layer)
            3'd0:    out_bytes_f = 17'd256;
            3'd1:    out_bytes_f = 17'd1024;
            3'd2:    out_bytes_f = 17'd4096;
            3'd3:    out_bytes_f = 17'd16384;
            3'd4:    out_bytes_f = 17'd65536;
            default: out_bytes_f = 17'd0;
        endcase
    endfunction

    state_t                state_r;
    logic                  mm2s_valid_r;
    logic                  s2mm_valid_r;
    logic [ADDR_WIDTH-1:0] mm2s_addr_r;
    logic [ADDR_WIDTH-1:0] s2mm_addr_r;
    logic [16:0]           mm2s_len_r;
    logic [16:0]           s2mm_len_r;
    logic                  up_start_r;
    logic [2:0]            up_size_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic [2:0]            cur_layer_r;
    logic [8:0]            cur_channel_r;
    logic [2:0]            last_layer_r;
    logic [ADDR_WIDTH-1:0] src_ptr_r;
    logic [ADDR_WIDTH-1:0] dst_ptr_r;
    logic                  rd_acc_r;
    logic                  wr_acc_r;
    logic [31:0]           wait_cnt_r;
    logic [2:0]            cmpl_r;

    logic                  cfg_ok_s;
    logic                  rd_hs_s;
    logic                  wr_hs_s;
    logic                  both_acc_s;
    logic [2:0]            dones_s;
    logic                  all_done_s;
    logic                  last_ch_s;
    logic [2:0]            issue_layer_s;
    logic [ADDR_WIDTH-1:0] next_src_s;
    logic [ADDR_WIDTH-1:0] next_dst_s;

    assign cfg_ok_s      = (first_layer <= last_layer) && (last_layer <= 3'd4);
    assign rd_hs_s       = mm2s_valid_r & bus.mm2s_cmd_ready;
    assign wr_hs_s       = s2mm_valid_r & bus.s2mm_cmd_ready;
    assign both_acc_s    = (rd_acc_r | rd_hs_s) & (wr_acc_r | wr_hs_s);
    assign dones_s       = {bus.up_done, bus.s2mm_done, bus.mm2s_done};
    // A pulse arriving in the same cycle as the last missing flag still completes the channel.
    assign all_done_s    = &(cmpl_r | dones_s);
    assign last_ch_s     = (cur_channel_r == {1'b0, last_channel_f(cur_layer_r)});
    assign issue_layer_s = last_ch_s ? (cur_layer_r + 3'd1) : cur_layer_r;
    assign next_src_s    = src_ptr_r + {{PAD_W{1'b0}}, in_bytes_f(cur_layer_r)};
    assign next_dst_s    = dst_ptr_r + {{PAD_W{1'b0}}, out_bytes_f(cur_layer_r)};

    assign bus.mm2s_cmd_valid = mm2s_valid_r;
    assign bus.mm2s_addr      = mm2s_addr_r;
    assign bus.mm2s_len       = mm2s_len_r;
    assign bus.s2mm_cmd_valid = s2mm_valid_r;
    assign bus.s2mm_addr      = s2mm_addr_r;
    assign bus.s2mm_len       = s2mm_len_r;
    assign bus.up_start       = up_start_r;
    assign bus.up_size        = up_size_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign error              = error_r;
    assign cur_layer          = cur_layer_r;
    assign cur_channel        = cur_channel_r;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            mm2s_valid_r  <= 1'b0;
            s2mm_valid_r  <= 1'b0;
            mm2s_addr_r   <= '0;
            s2mm_addr_r   <= '0;
            mm2s_len_r    <= 17'd0;
            s2mm_len_r    <= 17'd0;
            up_start_r    <= 1'b0;
            up_size_r     <= 3'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            cur_layer_r   <= 3'd0;
            cur_channel_r <= 9'd0;
            last_layer_r  <= 3'd0;
            src_ptr_r     <= '0;
            dst_ptr_r     <= '0;
            rd_acc_r      <= 1'b0;
            wr_acc_r      <= 1'b0;
            wait_cnt_r    <= 32'd0;
        end else begin
            up_start_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (go) begin
                        if (cfg_ok_s) begin
                            cur_layer_r   <= first_layer;
                            cur_channel_r <= 9'd0;
                            last_layer_r  <= last_layer;
                            src_ptr_r     <= SRC_BASE;
                            dst_ptr_r     <= DST_BASE;
                            mm2s_addr_r   <= SRC_BASE;
                            s2mm_addr_r   <= DST_BASE;
                            mm2s_len_r    <= in_bytes_f(first_layer);
                            s2mm_len_r    <= out_bytes_f(first_layer);
                            mm2s_valid_r  <= 1'b1;
                            s2mm_valid_r  <= 1'b1;
                            rd_acc_r      <= 1'b0;
                            wr_acc_r      <= 1'b0;
                            busy_r        <= 1'b1;
                            state_r       <= ISSUE;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= ERROR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (rd_hs_s) begin
                        mm2s_valid_r <= 1'b0;
                        rd_acc_r     <= 1'b1;
                    end
                    if (wr_hs_s) begin
                        s2mm_valid_r <= 1'b0;
                        wr_acc_r     <= 1'b1;
                    end
                    if (both_acc_s) begin
                        rd_acc_r   <= 1'b0;
                        wr_acc_r   <= 1'b0;
                        up_start_r <= 1'b1;
                        up_size_r  <= cur_layer_r;
                        state_r    <= START;
                    end
                end
                START: begin
                    wait_cnt_r <= 32'd0;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (all_done_s) begin
                        state_r <= ADVANCE;
                    end else if (wait_cnt_r == WAIT_LAST_C) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ERROR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ADVANCE: begin
                    src_ptr_r <= next_src_s;
                    dst_ptr_r <= next_dst_s;
                    if (last_ch_s && (cur_layer_r == last_layer_r)) begin
                        cur_channel_r <= 9'd0;
                        done_r        <= 1'b1;
                        state_r       <= FINISH;
                    end else begin
                        cur_channel_r <= last_ch_s ? 9'd0 : (cur_channel_r + 9'd1);
                        cur_layer_r   <= issue_layer_s;
                        mm2s_addr_r   <= next_src_s;
                        s2mm_addr_r   <= next_dst_s;
                        mm2s_len_r    <= in_bytes_f(issue_layer_s);
                        s2mm_len_r    <= out_bytes_f(issue_layer_s);
                        mm2s_valid_r  <= 1'b1;
                        s2mm_valid_r  <= 1'b1;
                        state_r       <= ISSUE;
                    end
                end
                FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                ERROR: begin
                    mm2s_valid_r <= 1'b0;
                    s2mm_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    error_r      <= 1'b1;
                    state_r      <= ERROR;
                end
                default: begin
                    mm2s_valid_r <= 1'b0;
                    s2mm_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    error_r      <= 1'b1;
                    state_r      <= ERROR;
                end
            endcase
        end
    end

    // Completion flags: capture done pulses from ISSUE through WAIT, drop them everywhere else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmpl_r <= 3'b000;
        end else if ((state_r == ISSUE) || (state_r == START) || (state_r == WAIT)) begin
            cmpl_r <= cmpl_r | dones_s;
        end else begin
            cmpl_r <= 3'b000;
        end
    end

endmodule

// File: tb/tb_upsample_layer_sequencer.sv
// Directed bench: single layer, full pass, backpressure, completion ordering,
// timeout, bad config and reset behaviour of upsample_layer_sequencer.
module tb_upsample_layer_sequencer;

    localparam logic [31:0] SRC = 32'h1000_0000;
    localparam logic [31:0] DST = 32'h2000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic [2:0] first_layer = 3'd0;
    logic [2:0] last_layer = 3'd0;
    logic       busy, done, error;
    logic [2:0] cur_layer;
    logic [8:0] cur_channel;

    logic auto_en = 1'b0;
    logic man_rd_rdy = 1'b0, man_wr_rdy = 1'b0;
    logic man_rd_done = 1'b0, man_wr_done = 1'b0, man_up_done = 1'b0;
    logic a_done = 1'b0;
    int   done_dly = 10;

    int total = 0;
    int bad = 0;

    upsample_layer_sequencer_if #(.ADDR_WIDTH(32)) bus ();

    assign bus.mm2s_cmd_ready = auto_en ? 1'b1 : man_rd_rdy;
    assign bus.s2mm_cmd_ready = auto_en ? 1'b1 : man_wr_rdy;
    assign bus.mm2s_done      = auto_en ? a_done : man_rd_done;
    assign bus.s2mm_done      = auto_en ? a_done : man_wr_done;
    assign bus.up_done        = auto_en ? a_done : man_up_done;

    upsample_layer_sequencer #(
        .ADDR_WIDTH     (32),
        .SRC_BASE       (32'h1000_0000),
        .DST_BASE       (32'h2000_0000),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .first_layer (first_layer),
        .last_layer  (last_layer),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cur_layer   (cur_layer),
        .cur_channel (cur_channel)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] m_in(input logic [2:0] l);
        case (l)
            3'd0: m_in = 17'd64;
            3'd1: m_in = 17'd256;
            3'd2: m_in = 17'd1024;
            3'd3: m_in = 17'd4096;
            default: m_in = 17'd16384;
        endcase
    endfunction

    function automatic logic [16:0] m_out(input logic [2:0] l);
        m_out = m_in(l) * 17'd4;
    endfunction

    function automatic logic [8:0] m_chans(input logic [2:0] l);
        m_chans = (l == 3'd4) ? 9'd128 : 9'd256;
    endfunction

    // Responder and reference model: counts starts/dones, checks every accepted command.
    int          up_cnt = 0, done_cnt = 0, model_err = 0, dly = 0;
    logic [2:0]  m_layer = 3'd0;
    logic [8:0]  m_ch = 9'd0;
    logic [31:0] m_src = 32'd0, m_dst = 32'd0, cap_src = 32'd0, cap_dst = 32'd0;

    initial forever begin
        @(negedge clk);
        a_done = 1'b0;
        if (!busy) begin
            m_layer = first_layer;
            m_ch    = 9'd0;
            m_src   = SRC;
            m_dst   = DST;
        end
        if (bus.mm2s_cmd_valid && bus.mm2s_cmd_ready) begin
            if (bus.mm2s_addr !== m_src || bus.mm2s_len !== m_in(m_layer)) model_err++;
            if (m_layer == 3'd1 && m_ch == 9'd0) cap_src = bus.mm2s_addr;
        end
        if (bus.s2mm_cmd_valid && bus.s2mm_cmd_ready) begin
            if (bus.s2mm_addr !== m_dst || bus.s2mm_len !== m_out(m_layer)) model_err++;
            if (m_layer == 3'd1 && m_ch == 9'd0) cap_dst = bus.s2mm_addr;
        end
        if (done) done_cnt++;
        if (bus.up_start) begin
            up_cnt++;
            if (bus.up_size !== m_layer) model_err++;
            m_src = m_src + {15'd0, m_in(m_layer)};
            m_dst = m_dst + {15'd0, m_out(m_layer)};
            if (m_ch == m_chans(m_layer) - 9'd1) begin
                m_ch    = 9'd0;
                m_layer = m_layer + 3'd1;
            end else begin
                m_ch = m_ch + 9'd1;
            end
            dly = done_dly;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) a_done = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val(tag, {63'd0, seen}, 64'd1);
    endtask

    task automatic check_reset_state(input string p);
        check_val({p, "_busy"}, {63'd0, busy}, 64'd0);
        check_val({p, "_done"}, {63'd0, done}, 64'd0);
        check_val({p, "_error"}, {63'd0, error}, 64'd0);
        check_val({p, "_valids"}, {62'd0, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid}, 64'd0);
        check_val({p, "_up_start"}, {63'd0, bus.up_start}, 64'd0);
        check_val({p, "_up_size"}, {61'd0, bus.up_size}, 64'd0);
        check_val({p, "_layer_chan"}, {52'd0, cur_layer, cur_channel}, 64'd0);
        check_val({p, "_addrs"}, {bus.mm2s_addr, bus.s2mm_addr}, 64'd0);
        check_val({p, "_lens"}, {30'd0, bus.mm2s_len, bus.s2mm_len}, 64'd0);
    endtask

    int b_up, b_done, b_err, stable_err, wait_n, idle_err;

    initial begin
        tick(3);
        check_reset_state("rst");
        reset = 1'b1;
        tick(1);

        // Single layer 4: 128 channels, dones 10 cycles after each start.
        auto_en = 1'b1; done_dly = 10; first_layer = 3'd4; last_layer = 3'd4;
        tick(2);
        b_up = up_cnt; b_done = done_cnt; b_err = model_err;
        pulse_go;
        check_val("sl_valid_n1", {62'd0, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid}, 64'd3);
        check_val("sl_rd_cmd", {15'd0, bus.mm2s_addr, bus.mm2s_len}, {15'd0, 32'h1000_0000, 17'd16384});
        check_val("sl_wr_cmd", {15'd0, bus.s2mm_addr, bus.s2mm_len}, {15'd0, 32'h2000_0000, 17'd65536});
        tick(1);
        check_val("sl_up_start_n2", {60'd0, bus.up_start, bus.up_size}, {60'd0, 1'b1, 3'd4});
        wait_done(5000, "sl_done_seen");
        tick(2);
        check_val("sl_starts", up_cnt - b_up, 64'd128);
        check_val("sl_done_pulses", done_cnt - b_done, 64'd1);
        check_val("sl_model", model_err - b_err, 64'd0);
        check_val("sl_busy_end", {63'd0, busy}, 64'd0);

        // Full pass 0..4 with a bad-config go mid-run that must be ignored.
        done_dly = 2; first_layer = 3'd0; last_layer = 3'd4;
        tick(2);
        b_up = up_cnt; b_done = done_cnt; b_err = model_err;
        pulse_go;
        tick(500);
        first_layer = 3'd3; last_layer = 3'd1;
        pulse_go;
        tick(2);
        check_val("fp_go_ignored", {62'd0, error, busy}, 64'd1);
        wait_done(20000, "fp_done_seen");
        check_val("fp_busy_at_done", {63'd0, busy}, 64'd1);
        tick(1);
        check_val("fp_busy_done_fall", {62'd0, busy, done}, 64'd0);
        tick(2);
        check_val("fp_starts", up_cnt - b_up, 64'd1152);
        check_val("fp_done_pulses", done_cnt - b_done, 64'd1);
        check_val("fp_model", model_err - b_err, 64'd0);
        check_val("fp_l1_src", cap_src, 64'h1000_4000);
        check_val("fp_l1_dst", cap_dst, 64'h2001_0000);

        // Backpressure: read ready held low 20 cycles, write accepted at once.
        auto_en = 1'b0; man_rd_rdy = 1'b0; man_wr_rdy = 1'b1;
        first_layer = 3'd2; last_layer = 3'd2;
        tick(2);
        pulse_go;
        check_val("bp_valids", {62'd0, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid}, 64'd3);
        check_val("bp_wr_cmd", {15'd0, bus.s2mm_addr, bus.s2mm_len}, {15'd0, 32'h2000_0000, 17'd4096});
        tick(1);
        check_val("bp_wr_drop", {63'd0, bus.s2mm_cmd_valid}, 64'd0);
        stable_err = 0;
        for (int i = 0; i < 19; i++) begin
            if (!bus.mm2s_cmd_valid || bus.mm2s_addr !== SRC || bus.mm2s_len !== 17'd1024 || bus.up_start)
                stable_err++;
            tick(1);
        end
        check_val("bp_rd_stable", stable_err, 64'd0);
        man_rd_rdy = 1'b1;
        tick(1);
        check_val("bp_start_after_acc", {59'd0, bus.up_start, bus.mm2s_cmd_valid, bus.up_size}, {59'd0, 1'b1, 1'b0, 3'd2});

        // Completion ordering: mm2s_done during START, the other two together later.
        man_rd_done = 1'b1;
        tick(1);
        man_rd_done = 1'b0;
        tick(5);
        check_val("co_withheld", {54'd0, bus.mm2s_cmd_valid, cur_channel}, 64'd0);
        man_up_done = 1'b1; man_wr_done = 1'b1;
        tick(1);
        man_up_done = 1'b0; man_wr_done = 1'b0;
        tick(1);
        check_val("co_advance", {54'd0, bus.mm2s_cmd_valid, cur_channel}, {54'd0, 1'b1, 9'd1});
        check_val("co_next_addrs", {bus.mm2s_addr, bus.s2mm_addr}, {32'h1000_0400, 32'h2000_1000});
        tick(1);
        check_val("co_start2", {63'd0, bus.up_start}, 64'd1);

        // Timeout: s2mm_done withheld on channel 1.
        man_rd_done = 1'b1; man_up_done = 1'b1;
        wait_n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            man_rd_done = 1'b0; man_up_done = 1'b0;
            if (error) break;
            wait_n++;
        end
        check_val("to_wait_cycles", wait_n, 64'd100);
        check_val("to_err_state", {60'd0, error, busy, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid}, 64'd8);
        check_val("to_channel", {55'd0, cur_channel}, 64'd1);
        first_layer = 3'd0; last_layer = 3'd0;
        tick(1);
        pulse_go;
        idle_err = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.mm2s_cmd_valid || bus.s2mm_cmd_valid || busy || !error) idle_err++;
            tick(1);
        end
        check_val("to_stuck", idle_err, 64'd0);
        reset = 1'b0;
        tick(1);
        check_val("to_reset_clears", {63'd0, error}, 64'd0);
        reset = 1'b1;
        tick(1);

        // Bad configuration.
        first_layer = 3'd3; last_layer = 3'd1;
        tick(1);
        pulse_go;
        check_val("bc_error", {60'd0, error, busy, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid}, 64'd8);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;

        // Reset while waiting on layer 3.
        man_rd_rdy = 1'b1; man_wr_rdy = 1'b1;
        first_layer = 3'd3; last_layer = 3'd3;
        tick(2);
        pulse_go;
        tick(1);
        check_val("mr_start", {60'd0, bus.up_start, bus.up_size}, {60'd0, 1'b1, 3'd3});
        tick(3);
        check_val("mr_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        tick(1);
        check_reset_state("mr");
        reset = 1'b1;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upsample_layer_sequencer.md
# upsample_layer_sequencer

Schedules the full multi-layer upsampling pass of the generator: for each layer in a programmable range, and for each channel of that layer, it issues one DMA read command, one DMA write command and one start pulse to the upsample AXI-stream core. It waits for all three completions before moving to the next channel. It sits between the PS-side control registers and the upsample core/DMA pair, replacing software per-channel sequencing.

## Interface
- ADDR_WIDTH, 32, DDR byte-address width
- SRC_BASE, 32'h1000_0000, byte address of first input channel
- DST_BASE, 32'h2000_0000, byte address of first output channel
- TIMEOUT_CYCLES, 65535, max cycles allowed in WAIT per channel

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- go  in  1  start pulse; sampled only in IDLE
- first_layer  in  3  first layer code (0..4)
- last_layer  in  3  last layer code (0..4)
- mm2s_cmd_valid / mm2s_cmd_ready  out / in  1  read-command handshake
- mm2s_addr  out  ADDR_WIDTH  read source address
- mm2s_len  out  17  read length in bytes
- s2mm_cmd_valid / s2mm_cmd_ready  out / in  1  write-command handshake
- s2mm_addr  out  ADDR_WIDTH  write destination address
- s2mm_len  out  17  write length in bytes
- mm2s_done, s2mm_done, up_done  in  1  single-cycle completion pulses
- up_start  out  1  one-cycle start to upsample core
- up_size  out  3  size code for core (= current layer)
- busy  out  1  high from ISSUE through FINISH
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky error flag
- cur_layer  out  3  current layer code
- cur_channel  out  9  current channel index

## Operation
- Layer table (fixed): code 0..4 → channels 256,256,256,256,128; pixels_in 16,64,256,1024,4096. in_bytes = pixels_in·4; out_bytes = in_bytes·4 (17-bit).
- States: IDLE, ISSUE, START, WAIT, ADVANCE, FINISH, ERROR.
- IDLE:
  - on go, if first_layer ≤ last_layer ≤ 4: load cur_layer=first_layer, cur_channel=0, src_ptr=SRC_BASE, dst_ptr=DST_BASE, then go to ISSUE.
  - otherwise set error and go to ERROR.
- ISSUE:
  - assert both cmd_valids with addr = src_ptr/dst_ptr and len = in_bytes/out_bytes.
  - each valid drops independently in the cycle after its own handshake; addr/len held stable while valid.
  - when both are accepted → START.
- START: up_start=1 for exactly one cycle, up_size=cur_layer → WAIT.
- Completion flags: three flags latch mm2s_done/s2mm_done/up_done in ISSUE, START and WAIT, in any order and including simultaneously. Flags are cleared in ADVANCE.
- WAIT:
  - when all three flags are set → ADVANCE.
  - wait counter increments each cycle in WAIT; reaching TIMEOUT_CYCLES sets error → ERROR.
- ADVANCE:
  - src_ptr += in_bytes, dst_ptr += out_bytes (pointers contiguous across layers, wrap modulo 2^ADDR_WIDTH).
  - if cur_channel = channels−1: cur_channel=0, cur_layer+1; past last_layer → FINISH, else → ISSUE.
  - otherwise cur_channel+1 → ISSUE.
- FINISH: done=1 for one cycle → IDLE.
- ERROR: all valids low, busy low, error held; exits only via reset.
- go is ignored outside IDLE.

## Timing
- Reset values: all valids 0, up_start 0, busy 0, done 0, error 0, cur_layer 0, cur_channel 0, addrs 0, lens 0, up_size 0.
- go in cycle N → cmd_valids high in N+1.
- Both readys high on first valid cycle → up_start in N+2.
- Last flag set in WAIT cycle M → ADVANCE in M+1, next ISSUE in M+2.
- A completion pulse in the same cycle the FSM enters ADVANCE is not counted; the downstream contract forbids this case.
- Reset mid-run: every output returns to its reset value in the cycle after reset is sampled low.

## Test plan
- Single layer: first=last=4, readys tied 1, dones 10 cycles after up_start → 128 channels; mm2s_addr = 0x1000_0000 + k·16384, len 16384; s2mm_addr = 0x2000_0000 + k·65536, len 65536; up_size=4; one done pulse.
- Full pass 0..4 → 1152 up_start pulses. Layer 0→1 transition: mm2s_addr = 0x1000_4000 and s2mm_addr = 0x2001_0000 at channel 0 of layer 1. done once; busy falls with it.
- Backpressure: mm2s_cmd_ready low 20 cycles, s2mm ready immediately → s2mm_valid drops after 1 cycle, mm2s addr/len stable 20 cycles, up_start only after mm2s accept.
- Completion ordering:
  - mm2s_done during START, then up_done+s2mm_done in the same cycle → exactly one advance.
  - Any single done withheld → no advance.
- Timeout: TIMEOUT_CYCLES=100, s2mm_done withheld → error=1 after 100 WAIT cycles, no further commands, busy 0; reset clears error.
- Bad config: first=3, last=1 → error next cycle, no cmd_valid. go during run is ignored. Reset mid-WAIT → reset values next cycle.
